// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard controller. It handles data-memory freeze,
//            branch flush and load-use stall, and keeps statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RS_addr_i,
    input  logic [4:0]       IF_ID_RT_addr_i,
    input  logic [4:0]       ID_EX_RT_addr_i,
    input  logic             ID_EX_MemRead_i,
    input  logic             Branch_taken_i,
    input  logic             DMem_req_i,
    input  logic             DMem_ready_i,
    output logic             PC_Write_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Flush_o,
    output logic             EX_MEM_Flush_o,
    output logic             Freeze_o,
    output logic [CNT_W-1:0] Stall_cnt_o,
    output logic [CNT_W-1:0] Flush_cnt_o,
    output logic             Mem_timeout_o
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                timeout_q, timeout_d;

    logic                mem_stall;
    logic                load_use;
    logic                branch_flush;
    logic                load_stall;

    always_comb begin : comb_hazard
        mem_stall    = DMem_req_i & ~DMem_ready_i;
        load_use     = ID_EX_MemRead_i & (ID_EX_RT_addr_i != 5'd0) &
                       ((ID_EX_RT_addr_i == IF_ID_RS_addr_i) |
                        (ID_EX_RT_addr_i == IF_ID_RT_addr_i));
        // Freeze masks everything; a held branch simply fires once unfrozen.
        branch_flush = Branch_taken_i & ~mem_stall;
        load_stall   = load_use & ~mem_stall & ~Branch_taken_i;
    end

    always_comb begin : comb_outputs
        Freeze_o       = mem_stall;
        PC_Write_o     = ~mem_stall & ~load_stall;
        IF_ID_Write_o  = ~mem_stall & ~load_stall;
        IF_ID_Flush_o  = branch_flush;
        ID_EX_Flush_o  = branch_flush | load_stall;
        EX_MEM_Flush_o = branch_flush;
        Stall_cnt_o    = stall_cnt_q;
        Flush_cnt_o    = flush_cnt_q;
        Mem_timeout_o  = timeout_q;
    end

    always_comb begin : comb_fsm
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (DMem_ready_i) begin
                    state_d = RUN;
                end else if (wait_cnt_q != C_WAIT_MAX) begin
                    // Saturating at the threshold keeps the compare exact.
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin : comb_counters
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        timeout_d   = timeout_q | (wait_cnt_q == C_WAIT_MAX);
        if ((mem_stall | load_stall) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin : seq_regs
        if (!rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int P_CNT_W   = 4;
    localparam int P_TIMEOUT = 4;
    localparam int C_CNT_MAX = (1 << P_CNT_W) - 1;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b0;
    logic [4:0]           IF_ID_RS_addr_i = '0;
    logic [4:0]           IF_ID_RT_addr_i = '0;
    logic [4:0]           ID_EX_RT_addr_i = '0;
    logic                 ID_EX_MemRead_i = 1'b0;
    logic                 Branch_taken_i  = 1'b0;
    logic                 DMem_req_i      = 1'b0;
    logic                 DMem_ready_i    = 1'b0;
    logic                 PC_Write_o;
    logic                 IF_ID_Write_o;
    logic                 IF_ID_Flush_o;
    logic                 ID_EX_Flush_o;
    logic                 EX_MEM_Flush_o;
    logic                 Freeze_o;
    logic [P_CNT_W-1:0]   Stall_cnt_o;
    logic [P_CNT_W-1:0]   Flush_cnt_o;
    logic                 Mem_timeout_o;

    int total = 0;
    int bad   = 0;
    bit model_on = 1'b0;

    // model state
    bit m_waiting = 1'b0;
    int m_wait    = 0;
    int m_stall   = 0;
    int m_flush   = 0;
    bit m_to      = 1'b0;

    hazard_ctrl #(
        .CNT_W   (P_CNT_W),
        .TIMEOUT (P_TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .IF_ID_RS_addr_i (IF_ID_RS_addr_i),
        .IF_ID_RT_addr_i (IF_ID_RT_addr_i),
        .ID_EX_RT_addr_i (ID_EX_RT_addr_i),
        .ID_EX_MemRead_i (ID_EX_MemRead_i),
        .Branch_taken_i  (Branch_taken_i),
        .DMem_req_i      (DMem_req_i),
        .DMem_ready_i    (DMem_ready_i),
        .PC_Write_o      (PC_Write_o),
        .IF_ID_Write_o   (IF_ID_Write_o),
        .IF_ID_Flush_o   (IF_ID_Flush_o),
        .ID_EX_Flush_o   (ID_EX_Flush_o),
        .EX_MEM_Flush_o  (EX_MEM_Flush_o),
        .Freeze_o        (Freeze_o),
        .Stall_cnt_o     (Stall_cnt_o),
        .Flush_cnt_o     (Flush_cnt_o),
        .Mem_timeout_o   (Mem_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare outputs against the model on every falling edge, then advance it.
    always @(negedge clk_i) begin
        if (model_on) begin
            automatic bit fr  = DMem_req_i && !DMem_ready_i;
            automatic bit lu  = ID_EX_MemRead_i && (ID_EX_RT_addr_i != 0) &&
                                ((ID_EX_RT_addr_i == IF_ID_RS_addr_i) ||
                                 (ID_EX_RT_addr_i == IF_ID_RT_addr_i));
            automatic bit br  = Branch_taken_i && !fr;
            automatic bit st  = lu && !fr && !Branch_taken_i;
            chk("m_freeze",   Freeze_o,       fr);
            chk("m_pc_write", PC_Write_o,     !(fr || st));
            chk("m_ifid_wr",  IF_ID_Write_o,  !(fr || st));
            chk("m_ifid_fl",  IF_ID_Flush_o,  br);
            chk("m_idex_fl",  ID_EX_Flush_o,  br || st);
            chk("m_exmem_fl", EX_MEM_Flush_o, br);
            chk("m_stall_cnt", Stall_cnt_o,   m_stall);
            chk("m_flush_cnt", Flush_cnt_o,   m_flush);
            chk("m_timeout",  Mem_timeout_o,  m_to);
            if (!rst_i) begin
                m_waiting = 1'b0;
                m_wait    = 0;
                m_stall   = 0;
                m_flush   = 0;
                m_to      = 1'b0;
            end else begin
                if ((fr || st) && m_stall < C_CNT_MAX) m_stall++;
                if (br && m_flush < C_CNT_MAX) m_flush++;
                if (m_wait >= P_TIMEOUT) m_to = 1'b1;
                if (!m_waiting) begin
                    if (fr) begin
                        m_waiting = 1'b1;
                        m_wait    = 0;
                    end
                end else if (DMem_ready_i) begin
                    m_waiting = 1'b0;
                end else begin
                    m_wait++;
                end
            end
        end
    end

    task automatic step(input bit rst, input bit req, input bit rdy, input bit br,
                        input bit mr, input int exrt, input int rs, input int rt);
        @(posedge clk_i);
        #1;
        rst_i           = rst;
        DMem_req_i      = req;
        DMem_ready_i    = rdy;
        Branch_taken_i  = br;
        ID_EX_MemRead_i = mr;
        ID_EX_RT_addr_i = 5'(exrt);
        IF_ID_RS_addr_i = 5'(rs);
        IF_ID_RT_addr_i = 5'(rt);
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        // reset
        @(posedge clk_i);
        #1;
        model_on = 1'b1;
        @(negedge clk_i);
        #1;
        chk("rst_pc_write", PC_Write_o, 1);
        chk("rst_stall",    Stall_cnt_o, 0);
        chk("rst_flush",    Flush_cnt_o, 0);
        chk("rst_timeout",  Mem_timeout_o, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // load-use on rs
        step(1, 0, 0, 0, 1, 5, 5, 0);
        chk("lu_pc_write", PC_Write_o, 0);
        chk("lu_ifid_wr",  IF_ID_Write_o, 0);
        chk("lu_idex_fl",  ID_EX_Flush_o, 1);
        chk("lu_ifid_fl",  IF_ID_Flush_o, 0);
        chk("lu_stall0",   Stall_cnt_o, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_stall1",   Stall_cnt_o, 1);
        chk("lu_pc_after", PC_Write_o, 1);

        // register 0 never hazards
        step(1, 0, 0, 0, 1, 0, 0, 0);
        chk("r0_pc_write", PC_Write_o, 1);
        chk("r0_idex_fl",  ID_EX_Flush_o, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_stall",    Stall_cnt_o, 1);

        // branch beats load-use
        step(1, 0, 0, 1, 1, 7, 0, 7);
        chk("br_ifid_fl",  IF_ID_Flush_o, 1);
        chk("br_idex_fl",  ID_EX_Flush_o, 1);
        chk("br_exmem_fl", EX_MEM_Flush_o, 1);
        chk("br_pc_write", PC_Write_o, 1);
        chk("br_ifid_wr",  IF_ID_Write_o, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("br_flush_cnt", Flush_cnt_o, 1);
        chk("br_stall_cnt", Stall_cnt_o, 1);

        // three-cycle memory freeze
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            chk("mw_freeze", Freeze_o, 1);
            chk("mw_pc",     PC_Write_o, 0);
        end
        step(1, 1, 1, 0, 0, 0, 0, 0);
        chk("mw_ready_freeze", Freeze_o, 0);
        chk("mw_ready_pc",     PC_Write_o, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("mw_stall_cnt", Stall_cnt_o, 4);

        // branch held across a freeze
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 1, 0, 0, 0, 0);
            chk("bf_ifid_fl",  IF_ID_Flush_o, 0);
            chk("bf_exmem_fl", EX_MEM_Flush_o, 0);
        end
        step(1, 1, 1, 1, 0, 0, 0, 0);
        chk("bf_late_ifid",  IF_ID_Flush_o, 1);
        chk("bf_late_exmem", EX_MEM_Flush_o, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("bf_flush_cnt", Flush_cnt_o, 2);
        chk("bf_stall_cnt", Stall_cnt_o, 6);

        // timeout and stall-counter saturation
        for (int i = 1; i <= 14; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            if (i == 6) chk("to_not_yet", Mem_timeout_o, 0);
            if (i == 7) chk("to_set",     Mem_timeout_o, 1);
        end
        chk("sat_stall", Stall_cnt_o, 15);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_freeze_comb", Freeze_o, 1);
        chk("to_held",         Mem_timeout_o, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_to_clear",    Mem_timeout_o, 0);
        chk("rst_stall_clear", Stall_cnt_o, 0);
        chk("rst_flush_clear", Flush_cnt_o, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 9) < 4),
                 $urandom_range(0, 3),
                 $urandom_range(0, 3),
                 $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the statistics counters.
REQ-002 Parameter TIMEOUT, default 64: MEM_WAIT cycle count at which the timeout flag sets.
REQ-003 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  reset, synchronous, active-low.
REQ-005 Port IF_ID_RS_addr_i  input  5  rs field of the instruction in ID.
REQ-006 Port IF_ID_RT_addr_i  input  5  rt field of the instruction in ID.
REQ-007 Port ID_EX_RT_addr_i  input  5  rt (load destination) of the instruction in EX.
REQ-008 Port ID_EX_MemRead_i  input  1  the instruction in EX is a load.
REQ-009 Port Branch_taken_i  input  1  taken branch resolved in MEM this cycle.
REQ-010 Port DMem_req_i  input  1  the instruction in MEM accesses data memory.
REQ-011 Port DMem_ready_i  input  1  data memory completes the access this cycle.
REQ-012 Port PC_Write_o  output  1  PC register enable.
REQ-013 Port IF_ID_Write_o  output  1  IF/ID register enable.
REQ-014 Port IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o  output  1 each  load a bubble into that register.
REQ-015 Port Freeze_o  output  1  hold every pipeline register, PC and register-file writes.
REQ-016 Port Stall_cnt_o  output  CNT_W  count of stall cycles.
REQ-017 Port Flush_cnt_o  output  CNT_W  count of branch flushes.
REQ-018 Port Mem_timeout_o  output  1  sticky timeout flag.

Function
REQ-019 FSM states: RUN and MEM_WAIT; control outputs are combinational from the state and inputs; the state, counters and flag are registered.
REQ-020 mem_stall = DMem_req_i & ~DMem_ready_i; Freeze_o = mem_stall in both states.
REQ-021 RUN->MEM_WAIT when mem_stall=1; MEM_WAIT->RUN in the cycle after DMem_ready_i=1; otherwise the state holds.
REQ-022 Load-use = ID_EX_MemRead_i & (ID_EX_RT_addr_i!=0) & (ID_EX_RT_addr_i==IF_ID_RS_addr_i | ID_EX_RT_addr_i==IF_ID_RT_addr_i).
REQ-023 Priority is freeze > branch flush > load-use; a lower-priority condition produces no outputs while a higher one is active.
REQ-024 Freeze active: PC_Write_o=0, IF_ID_Write_o=0, all flush outputs 0.
REQ-025 Branch flush, no freeze: IF_ID_Flush_o=ID_EX_Flush_o=EX_MEM_Flush_o=1, PC_Write_o=1, IF_ID_Write_o=1.
REQ-026 Load-use, no freeze or branch: PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1; the bubble lasts exactly one cycle because the next cycle ID_EX_MemRead_i=0.
REQ-027 No condition active: PC_Write_o=IF_ID_Write_o=1, all flush outputs 0.
REQ-028 A Branch_taken_i held during a freeze takes effect in the first unfrozen cycle.
REQ-029 Stall_cnt_o increments by 1 each cycle in which Freeze_o or the load-use stall is asserted, and saturates at all-ones.
REQ-030 Flush_cnt_o increments by 1 each cycle in which the branch flush is asserted, and saturates at all-ones.
REQ-031 The wait counter clears on entering MEM_WAIT and increments each MEM_WAIT cycle with DMem_ready_i=0.
REQ-032 When the wait counter reaches TIMEOUT, Mem_timeout_o is set the next edge and stays 1 until reset; the FSM keeps waiting.

Reset
REQ-033 rst_i=0 at a clock edge: state=RUN, wait counter=0, Stall_cnt_o=0, Flush_cnt_o=0, Mem_timeout_o=0.
REQ-034 Combinational outputs follow REQ-020..027 during reset.
REQ-035 Reset asserted during MEM_WAIT returns the block to RUN on that edge, regardless of DMem_ready_i.

Verification
REQ-036 ID_EX_MemRead=1, ID_EX_RT=5, IF_ID_RS=5 -> one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; Stall_cnt 0->1.
REQ-037 ID_EX_MemRead=1, ID_EX_RT=0, IF_ID_RT=0 -> no stall; PC_Write=1.
REQ-038 Branch_taken=1 together with a load-use hit -> three flushes=1, PC_Write=1, no stall; Flush_cnt +1, Stall_cnt unchanged.
REQ-039 DMem_req=1 with ready=0 for 3 cycles, then ready=1 -> Freeze=1 for 3 cycles, 0 on the ready cycle; Stall_cnt +3; state RUN afterwards.
REQ-040 Branch_taken=1 during a 2-cycle freeze -> no flushes while frozen; flushes in the first unfrozen cycle.
REQ-041 TIMEOUT=4, ready held 0 -> Mem_timeout=1 after the 4th wait count and held; rst_i=0 -> flag, counters cleared, state RUN.
